mram_burst_reg_ctrl: RTL

//  I2C-register-mapped controller for an asynchronous parallel MRAM with CE/OE/WE/LB/UB strobes.

---
 rtl/mram_burst_reg_ctrl_if.sv | 42 ++++
 rtl/mram_burst_reg_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mram_burst_reg_ctrl_if.sv
// Signal bundle for the MRAM burst controller: I2C register port, MRAM pins,
// status strobes and a debug view of the sequencer state.
interface mram_burst_reg_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    // Register port: writeEn is a single-cycle strobe with no back-pressure; the
    // controller always accepts it. A GO or config write that arrives while busy
    // is dropped and reported through the sticky ERR bit instead of stalling.
    logic [7:0]        addr;
    logic [7:0]        dataIn;
    logic              writeEn;
    logic [7:0]        dataOut;

    logic [ADDR_W-1:0] mram_addr;
    logic [DATA_W-1:0] mram_dq_o;
    logic [DATA_W-1:0] mram_dq_i;
    logic              mram_dq_oe;
    logic              mram_ce_n;
    logic              mram_oe_n;
    logic              mram_we_n;
    logic              mram_lb_n;
    logic              mram_ub_n;

    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    modport slave (
        input  addr, dataIn, writeEn, mram_dq_i,
        output dataOut, mram_addr, mram_dq_o, mram_dq_oe,
        output mram_ce_n, mram_oe_n, mram_we_n, mram_lb_n, mram_ub_n,
        output busy, done, dbg_state
    );

    modport master (
        output addr, dataIn, writeEn, mram_dq_i,
        input  dataOut, mram_addr, mram_dq_o, mram_dq_oe,
        input  mram_ce_n, mram_oe_n, mram_we_n, mram_lb_n, mram_ub_n,
        input  busy, done, dbg_state
    );
endinterface

// File: rtl/mram_burst_reg_ctrl.sv
// Register-mapped burst controller for an asynchronous parallel MRAM: an 8-entry
// data buffer, auto-incrementing address and a SETUP/ACCESS/RECOV beat sequencer.
module mram_burst_reg_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int ACCESS_CYC = 5,
    parameter int RECOV_CYC  = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    mram_burst_reg_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RECOV  = 2'd3
    } state_t;

    localparam int CNT_MAX = (ACCESS_CYC > RECOV_CYC) ? ACCESS_CYC : RECOV_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] ACC_LAST = CW'(ACCESS_CYC - 1);
    localparam logic [CW-1:0] REC_LAST = CW'(RECOV_CYC - 1);
    localparam logic UB_ACC = (DATA_W == 8);

    // Register file
    logic        ctrl_rw_q,   ctrl_rw_d;
    logic [2:0]  ctrl_blen_q, ctrl_blen_d;
    logic [23:0] addr_reg_q,  addr_reg_d;
    logic [2:0]  idx_q,       idx_d;
    logic        err_q,       err_d;
    logic [7:0]  dataout_q,   dataout_d;
    logic [7:0]  addr_prev_q;
    logic [7:0]  dbuf_lo_q [8];
    logic [7:0]  dbuf_hi_q [8];

    // Beat sequencer
    state_t            state_q;
    logic [CW-1:0]     cyc_q;
    logic [2:0]        beat_q;
    logic [2:0]        beats_left_q;
    logic              rw_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] dq_o_q;
    logic              dq_oe_q;
    logic              ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
    logic              busy_q, done_q, done_bit_q;

    logic        wr_ok;
    logic        go;
    logic        cap_en;
    logic [2:0]  beat_nx;
    logic [15:0] word_nx;
    logic [15:0] dq_in16;

    // busy_q is high exactly while the sequencer is away from IDLE.
    assign wr_ok   = bus.writeEn && !busy_q;
    assign go      = wr_ok && (bus.addr == 8'h07) && bus.dataIn[0];
    assign cap_en  = (state_q == ST_ACCESS) && (cyc_q == ACC_LAST) && !rw_q;
    assign beat_nx = (state_q == ST_IDLE) ? 3'd0 : beat_q + 3'd1;
    assign word_nx = {dbuf_hi_q[beat_nx], dbuf_lo_q[beat_nx]};
    assign dq_in16 = 16'(bus.mram_dq_i);

    always_comb begin
        ctrl_rw_d   = ctrl_rw_q;
        ctrl_blen_d = ctrl_blen_q;
        addr_reg_d  = addr_reg_q;
        idx_d       = idx_q;
        err_d       = err_q;
        dataout_d   = 8'h00;

        if (wr_ok) begin
            case (bus.addr)
                8'h00: begin
                    ctrl_rw_d   = bus.dataIn[0];
                    ctrl_blen_d = bus.dataIn[7:5];
                end
                8'h01: addr_reg_d[7:0]   = bus.dataIn;
                8'h02: addr_reg_d[15:8]  = bus.dataIn;
                8'h03: addr_reg_d[23:16] = bus.dataIn;
                8'h06: idx_d             = bus.dataIn[2:0];
                default: ;
            endcase
        end

        // DATA_HI steps IDX once per fresh selection or per accepted write.
        if ((bus.addr == 8'h05) && ((addr_prev_q != 8'h05) || wr_ok))
            idx_d = idx_q + 3'd1;

        if (bus.writeEn) begin
            if (busy_q && (bus.addr <= 8'h06))
                err_d = 1'b1;
            if (bus.addr == 8'h07) begin
                if (bus.dataIn[1])
                    err_d = 1'b0;
                if (bus.dataIn[0] && busy_q)
                    err_d = 1'b1;
            end
        end

        case (bus.addr)
            8'h00: dataout_d = {ctrl_blen_q, 4'b0000, ctrl_rw_q};
            8'h01: dataout_d = addr_reg_q[7:0];
            8'h02: dataout_d = addr_reg_q[15:8];
            8'h03: dataout_d = addr_reg_q[23:16];
            8'h04: dataout_d = dbuf_lo_q[idx_q];
            8'h05: dataout_d = (DATA_W == 16) ? dbuf_hi_q[idx_q] : 8'h00;
            8'h06: dataout_d = {5'b00000, idx_q};
            8'h07: dataout_d = {5'b00000, err_q, done_bit_q, busy_q};
            default: dataout_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_rw_q   <= 1'b0;
            ctrl_blen_q <= 3'd0;
            addr_reg_q  <= 24'd0;
            idx_q       <= 3'd0;
            err_q       <= 1'b0;
            dataout_q   <= 8'h00;
            addr_prev_q <= 8'h00;
        end else begin
            ctrl_rw_q   <= ctrl_rw_d;
            ctrl_blen_q <= ctrl_blen_d;
            addr_reg_q  <= addr_reg_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            dataout_q   <= dataout_d;
            addr_prev_q <= bus.addr;
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            dbuf_lo_q[beat_q] <= dq_in16[7:0];
            dbuf_hi_q[beat_q] <= dq_in16[15:8];
        end else if (wr_ok && (bus.addr == 8'h04)) begin
            dbuf_lo_q[idx_q] <= bus.dataIn;
        end else if (wr_ok && (bus.addr == 8'h05) && (DATA_W == 16)) begin
            dbuf_hi_q[idx_q] <= bus.dataIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            beat_q       <= 3'd0;
            beats_left_q <= 3'd0;
            rw_q         <= 1'b0;
            maddr_q      <= '0;
            dq_o_q       <= '0;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            lb_n_q       <= 1'b1;
            ub_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_bit_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        rw_q         <= ctrl_rw_q;
                        beats_left_q <= ctrl_blen_q;
                        beat_q       <= 3'd0;
                        maddr_q      <= addr_reg_q[ADDR_W-1:0];
                        dq_o_q       <= word_nx[DATA_W-1:0];
                        dq_oe_q      <= ctrl_rw_q;
                        busy_q       <= 1'b1;
                        done_bit_q   <= 1'b0;
                        state_q      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cyc_q   <= '0;
                    ce_n_q  <= 1'b0;
                    lb_n_q  <= 1'b0;
                    ub_n_q  <= UB_ACC;
                    we_n_q  <= !rw_q;
                    oe_n_q  <= rw_q;
                    dq_oe_q <= rw_q;
                    state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (cyc_q == ACC_LAST) begin
                        cyc_q   <= '0;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        lb_n_q  <= 1'b1;
                        ub_n_q  <= 1'b1;
                        dq_oe_q <= rw_q;
                        state_q <= ST_RECOV;
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                ST_RECOV: begin
                    // Write data is held on the pad for the first recovery cycle only.
                    dq_oe_q <= 1'b0;
                    if (cyc_q == REC_LAST) begin
                        if (beats_left_q != 3'd0) begin
                            beats_left_q <= beats_left_q - 3'd1;
                            beat_q       <= beat_nx;
                            maddr_q      <= maddr_q + ADDR_W'(1);
                            dq_o_q       <= word_nx[DATA_W-1:0];
                            dq_oe_q      <= rw_q;
                            state_q      <= ST_SETUP;
                        end else begin
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            done_bit_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.dataOut    = dataout_q;
    assign bus.mram_addr  = maddr_q;
    assign bus.mram_dq_o  = dq_o_q;
    assign bus.mram_dq_oe = dq_oe_q;
    assign bus.mram_ce_n  = ce_n_q;
    assign bus.mram_oe_n  = oe_n_q;
    assign bus.mram_we_n  = we_n_q;
    assign bus.mram_lb_n  = lb_n_q;
    assign bus.mram_ub_n  = ub_n_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.dbg_state  = state_q;
endmodule
